wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 35 +++
 rtl/wb_pend_fifo.sv | 77 +++++++
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared write-back constants, entry type and the
//               decode-field match helper used by the port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int REG_AW     = 5;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 2;
    localparam int AGE_W      = 3;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } pend_entry_t;

    // True when a queued destination collides with any nonzero decode field.
    function automatic logic rd_hits(input reg_addr_t entry_rd,
                                     input reg_addr_t rs1,
                                     input reg_addr_t rs2,
                                     input reg_addr_t rd);
        rd_hits = ((rs1 != '0) && (rs1 == entry_rd)) ||
                  ((rs2 != '0) && (rs2 == entry_rd)) ||
                  ((rd  != '0) && (rd  == entry_rd));
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_fifo
// Description : Two-entry in-order queue of pending multi-cycle results.
//               Slot 0 is always the head; a pop shifts slot 1 forward and
//               a push lands in the first free slot after that shift.
//               Also reports whether a decode field hits a queued rd.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  pend_entry_t      i_push_entry,
    input  logic             i_pop,
    input  reg_addr_t        i_rs1,
    input  reg_addr_t        i_rs2,
    input  reg_addr_t        i_rd,
    output pend_entry_t      o_head,
    output logic             o_head_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_match
);

    logic [FIFO_DEPTH-1:0] r_valid;
    pend_entry_t           r_slot0;
    pend_entry_t           r_slot1;

    logic [FIFO_DEPTH-1:0] w_valid_nxt;
    pend_entry_t           w_slot0_nxt;
    pend_entry_t           w_slot1_nxt;

    // Next-state: apply the pop shift first, then place a push in the first free slot.
    always_comb begin
        w_valid_nxt = r_valid;
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        if (i_pop) begin
            w_valid_nxt = {1'b0, r_valid[1]};
            w_slot0_nxt = r_slot1;
        end
        if (i_push) begin
            if (!w_valid_nxt[0]) begin
                w_valid_nxt[0] = 1'b1;
                w_slot0_nxt    = i_push_entry;
            end else begin
                w_valid_nxt[1] = 1'b1;
                w_slot1_nxt    = i_push_entry;
            end
        end
    end

    // Occupancy bits are the only reset state; stale payload is masked by them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Payload storage, intentionally without reset.
    always_ff @(posedge clk) begin
        r_slot0 <= w_slot0_nxt;
        r_slot1 <= w_slot1_nxt;
    end

    assign o_head       = r_slot0;
    assign o_head_valid = r_valid[0];
    assign o_count      = CNT_W'(r_valid[0]) + CNT_W'(r_valid[1]);
    assign o_match      = (r_valid[0] && rd_hits(r_slot0.rd, i_rs1, i_rs2, i_rd)) ||
                          (r_valid[1] && rd_hits(r_slot1.rd, i_rs1, i_rs2, i_rd));

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               pipeline WB stage (always wins) and a multi-cycle unit whose
//               results are bypassed or parked in a 2-entry queue. A head
//               that waits too long requests a WB bubble from the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int AGE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              MdValid,
    input  logic [REG_AW-1:0] MdRd,
    input  logic [DATA_W-1:0] MdResult,
    output logic              MdReady,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    output logic              PendHazardD,
    output logic              RfWE,
    output logic [REG_AW-1:0] RfA3,
    output logic [DATA_W-1:0] RfWD,
    output logic              ForceBubble,
    output logic [CNT_W-1:0]  PendCount
);

    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] AGE_SAT   = '1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    logic             w_pipe_own;
    logic             w_head_valid;
    logic             w_pop;
    logic             w_bypass;
    logic             w_accept;
    logic             w_push;
    logic [CNT_W-1:0] w_count;
    pend_entry_t      w_head;
    pend_entry_t      w_push_entry;
    logic [AGE_W-1:0] r_age;

    // Writes to x0 never claim the port, so they leave room for the Md side.
    assign w_pipe_own   = RegWriteW && (RdW != '0);
    assign w_pop        = !w_pipe_own && w_head_valid;
    assign w_bypass     = !w_pipe_own && !w_head_valid && MdValid && (MdRd != '0);
    // A pop frees a slot this same edge, so a full queue can still accept.
    assign MdReady      = (w_count < CNT_FULL) || w_pop;
    assign w_accept     = MdValid && MdReady;
    assign w_push       = w_accept && (MdRd != '0) && !w_bypass;
    assign w_push_entry = '{rd: MdRd, data: MdResult};

    wb_pend_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_rs1        (Rs1D),
        .i_rs2        (Rs2D),
        .i_rd         (RdD),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count),
        .o_match      (PendHazardD)
    );

    // Write-port mux: pipeline, then queued head, then bypass, else idle zeros.
    always_comb begin
        RfWE = 1'b0;
        RfA3 = '0;
        RfWD = '0;
        if (w_pipe_own) begin
            RfWE = 1'b1;
            RfA3 = RdW;
            RfWD = ResultW;
        end else if (w_head_valid) begin
            RfWE = 1'b1;
            RfA3 = w_head.rd;
            RfWD = w_head.data;
        end else if (w_bypass) begin
            RfWE = 1'b1;
            RfA3 = MdRd;
            RfWD = MdResult;
        end
    end

    // Head age: counts cycles the head is blocked, saturating, cleared on pop or empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_age <= '0;
        end else if (w_pop || !w_head_valid) begin
            r_age <= '0;
        end else if (r_age != AGE_SAT) begin
            r_age <= r_age + AGE_W'(1);
        end
    end

    assign PendCount   = w_count;
    assign ForceBubble = (w_count == CNT_FULL) && (r_age >= AGE_LIMIT);

endmodule
`default_nettype wire
